// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
package calc_pkg;
    localparam int CALC_WIDTH = 14;

    typedef enum logic [2:0] {ENTER_A, ENTER_B, COMPUTE, SHOW, ERROR} calc_state_t;
    typedef enum logic {OP_ADD, OP_SUB} calc_op_t;
endpackage

// File: rtl/calc_controller_if.sv
// Launch/complete link between the sequencer and the arithmetic unit.
// Handshake: master pulses alu_start for one cycle with alu_op stable; the slave later
// pulses alu_done for one cycle with alu_result/alu_overflow valid in that same cycle.
interface calc_controller_if import calc_pkg::*; #(
    parameter int WIDTH = CALC_WIDTH
) ();
    logic             alu_start;
    logic             alu_op;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;

    modport master (output alu_start, output alu_op,
                    input  alu_done, input alu_result, input alu_overflow);
    modport slave  (input  alu_start, input alu_op,
                    output alu_done, output alu_result, output alu_overflow);
endinterface

// File: rtl/calc_controller_op_timer.sv
// Saturating COMPUTE-cycle counter; expired is high once the count reaches OP_TIMEOUT-1.
module op_timer #(
    parameter  int OP_TIMEOUT = 64,
    localparam int TW         = $clog2(OP_TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam logic [TW-1:0] LAST = TW'(OP_TIMEOUT - 1);

    logic [TW-1:0] r_count;

    // Holds at LAST instead of wrapping so a missed clear cannot re-arm the timeout.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);
endmodule

// File: rtl/calc_controller.sv
// Calculator sequencer: operand entry A -> B, ALU launch/complete, result range check,
// display source selection and operand-clear strobe.
module calc_controller import calc_pkg::*; #(
    parameter int WIDTH      = CALC_WIDTH,
    parameter int MAX_VALUE  = 9999,
    parameter int OP_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_ent,
    input  logic              btn_clr,
    input  logic              arith_sel,
    input  logic [WIDTH-1:0]  number_1,
    input  logic [WIDTH-1:0]  number_2,
    calc_controller_if.master alu,
    output logic              write_en,
    output logic              write_sel,
    output logic              operand_clr,
    output logic [WIDTH-1:0]  display_number,
    output logic              display_blank,
    output logic              error,
    output calc_state_t       dbg_state
);
    localparam logic [WIDTH-1:0] MAX_RESULT = WIDTH'(MAX_VALUE);

    calc_state_t      r_state;
    calc_state_t      w_next;
    calc_op_t         r_alu_op;
    logic [WIDTH-1:0] r_result_q;
    logic             r_alu_start;
    logic             r_operand_clr;
    logic             r_write_en;
    logic             r_write_sel;
    logic             r_display_blank;
    logic             r_error;
    logic             w_timer_expired;
    logic             w_result_bad;
    logic             w_launch;

    op_timer #(.OP_TIMEOUT(OP_TIMEOUT)) u_op_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   ((r_state != COMPUTE) || btn_clr),
        .i_enable  (r_state == COMPUTE),
        .o_expired (w_timer_expired)
    );

    assign w_result_bad = alu.alu_overflow || (alu.alu_result > MAX_RESULT);
    assign w_launch     = (r_state == ENTER_B) && btn_ent && !btn_clr;

    always_comb begin
        w_next = r_state;
        if (btn_clr) begin
            w_next = ENTER_A;
        end else begin
            case (r_state)
                ENTER_A: if (btn_ent) w_next = ENTER_B;
                ENTER_B: if (btn_ent) w_next = COMPUTE;
                // A done arriving on the timeout cycle still counts as normal completion.
                COMPUTE: begin
                    if (alu.alu_done)         w_next = w_result_bad ? ERROR : SHOW;
                    else if (w_timer_expired) w_next = ERROR;
                end
                SHOW:    if (btn_ent) w_next = ENTER_A;
                ERROR:   if (btn_ent) w_next = ENTER_A;
                default: w_next = ENTER_A;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ENTER_A;
            r_result_q      <= '0;
            r_alu_op        <= OP_ADD;
            r_alu_start     <= 1'b0;
            r_operand_clr   <= 1'b0;
            r_write_en      <= 1'b1;
            r_write_sel     <= 1'b0;
            r_display_blank <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_write_en      <= (w_next == ENTER_A) || (w_next == ENTER_B);
            r_write_sel     <= (w_next == ENTER_B);
            r_display_blank <= (w_next == ERROR);
            r_error         <= (w_next == ERROR);
            r_alu_start     <= w_launch;
            r_operand_clr   <= btn_clr || ((r_state == ERROR) && btn_ent);
            if (w_launch) begin
                r_alu_op <= calc_op_t'(arith_sel);
            end
            if (btn_clr) begin
                r_result_q <= '0;
            end else if ((r_state == COMPUTE) && alu.alu_done) begin
                r_result_q <= alu.alu_result;
            end
        end
    end

    always_comb begin
        case (r_state)
            ENTER_A:          display_number = number_1;
            ENTER_B, COMPUTE: display_number = number_2;
            default:          display_number = r_result_q;
        endcase
    end

    assign alu.alu_start = r_alu_start;
    assign alu.alu_op    = r_alu_op;
    assign write_en      = r_write_en;
    assign write_sel     = r_write_sel;
    assign operand_clr   = r_operand_clr;
    assign display_blank = r_display_blank;
    assign error         = r_error;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: entry flow, ALU handshake, range/overflow, timeout, CLR priority.
module tb_calc_controller;
    import calc_pkg::*;

    localparam int W = 14;

    logic         clk;
    logic         reset;
    logic         btn_ent;
    logic         btn_clr;
    logic         arith_sel;
    logic [W-1:0] number_1;
    logic [W-1:0] number_2;
    logic         write_en;
    logic         write_sel;
    logic         operand_clr;
    logic [W-1:0] display_number;
    logic         display_blank;
    logic         error;
    calc_state_t  dbg_state;

    int total;
    int passed;

    calc_controller_if #(.WIDTH(W)) alu_if ();

    calc_controller #(.WIDTH(W), .MAX_VALUE(9999), .OP_TIMEOUT(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_ent        (btn_ent),
        .btn_clr        (btn_clr),
        .arith_sel      (arith_sel),
        .number_1       (number_1),
        .number_2       (number_2),
        .alu            (alu_if),
        .write_en       (write_en),
        .write_sel      (write_sel),
        .operand_clr    (operand_clr),
        .display_number (display_number),
        .display_blank  (display_blank),
        .error          (error),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ent();
        btn_ent = 1'b1;
        tick();
        btn_ent = 1'b0;
    endtask

    task automatic pulse_clr();
        btn_clr = 1'b1;
        tick();
        btn_clr = 1'b0;
    endtask

    task automatic pulse_done(input logic [W-1:0] res, input logic ovf);
        alu_if.alu_done     = 1'b1;
        alu_if.alu_result   = res;
        alu_if.alu_overflow = ovf;
        tick();
        alu_if.alu_done     = 1'b0;
        alu_if.alu_overflow = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (dbg_state !== ENTER_A) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ENTER_A); else passed++;
        total++; if (write_sel !== 1'b0) $display("FAIL reset_write_sel: got %0b expected 0", write_sel); else passed++;
        total++; if (write_en !== 1'b1) $display("FAIL reset_write_en: got %0b expected 1", write_en); else passed++;
        total++; if (display_number !== 14'd12) $display("FAIL reset_display: got %0d expected 12", display_number); else passed++;
        total++; if (alu_if.alu_start !== 1'b0) $display("FAIL reset_alu_start: got %0b expected 0", alu_if.alu_start); else passed++;
        total++; if (operand_clr !== 1'b0) $display("FAIL reset_operand_clr: got %0b expected 0", operand_clr); else passed++;
        total++; if (error !== 1'b0 || display_blank !== 1'b0) $display("FAIL reset_error_blank: got %0b%0b expected 00", error, display_blank); else passed++;
    endtask

    task automatic test_add();
        pulse_ent();
        total++; if (dbg_state !== ENTER_B) $display("FAIL add_enter_b: got %0d expected %0d", dbg_state, ENTER_B); else passed++;
        total++; if (write_sel !== 1'b1) $display("FAIL add_write_sel: got %0b expected 1", write_sel); else passed++;
        total++; if (display_number !== 14'd30) $display("FAIL add_display_b: got %0d expected 30", display_number); else passed++;
        arith_sel = 1'b0;
        pulse_ent();
        total++; if (alu_if.alu_start !== 1'b1) $display("FAIL add_start_hi: got %0b expected 1", alu_if.alu_start); else passed++;
        total++; if (alu_if.alu_op !== 1'b0) $display("FAIL add_alu_op: got %0b expected 0", alu_if.alu_op); else passed++;
        total++; if (write_en !== 1'b0) $display("FAIL add_write_en: got %0b expected 0", write_en); else passed++;
        pulse_ent();
        total++; if (alu_if.alu_start !== 1'b0) $display("FAIL add_start_lo: got %0b expected 0", alu_if.alu_start); else passed++;
        total++; if (dbg_state !== COMPUTE) $display("FAIL add_ent_ignored: got %0d expected %0d", dbg_state, COMPUTE); else passed++;
        tick();
        pulse_done(14'd42, 1'b0);
        total++; if (dbg_state !== SHOW) $display("FAIL add_show: got %0d expected %0d", dbg_state, SHOW); else passed++;
        total++; if (display_number !== 14'd42) $display("FAIL add_result: got %0d expected 42", display_number); else passed++;
        pulse_ent();
        total++; if (dbg_state !== ENTER_A || display_number !== 14'd12) $display("FAIL add_back_a: got %0d/%0d expected %0d/12", dbg_state, display_number, ENTER_A); else passed++;
        total++; if (operand_clr !== 1'b0) $display("FAIL add_no_clr: got %0b expected 0", operand_clr); else passed++;
    endtask

    task automatic test_overflow();
        arith_sel = 1'b1;
        pulse_ent();
        pulse_ent();
        total++; if (alu_if.alu_op !== 1'b1) $display("FAIL ovf_alu_op: got %0b expected 1", alu_if.alu_op); else passed++;
        pulse_done(14'd5, 1'b1);
        total++; if (dbg_state !== ERROR) $display("FAIL ovf_state: got %0d expected %0d", dbg_state, ERROR); else passed++;
        total++; if (error !== 1'b1 || display_blank !== 1'b1) $display("FAIL ovf_flags: got %0b%0b expected 11", error, display_blank); else passed++;
        pulse_ent();
        total++; if (dbg_state !== ENTER_A) $display("FAIL ovf_exit: got %0d expected %0d", dbg_state, ENTER_A); else passed++;
        total++; if (operand_clr !== 1'b1) $display("FAIL ovf_clr_hi: got %0b expected 1", operand_clr); else passed++;
        tick();
        total++; if (operand_clr !== 1'b0 || error !== 1'b0) $display("FAIL ovf_clr_lo: got %0b%0b expected 00", operand_clr, error); else passed++;
    endtask

    task automatic test_range();
        arith_sel = 1'b0;
        pulse_ent();
        pulse_ent();
        pulse_done(14'd10000, 1'b0);
        total++; if (dbg_state !== ERROR) $display("FAIL range_10000: got %0d expected %0d", dbg_state, ERROR); else passed++;
        total++; if (display_number !== 14'd10000) $display("FAIL range_err_disp: got %0d expected 10000", display_number); else passed++;
        pulse_clr();
        pulse_ent();
        pulse_ent();
        pulse_done(14'd9999, 1'b0);
        total++; if (dbg_state !== SHOW) $display("FAIL range_9999: got %0d expected %0d", dbg_state, SHOW); else passed++;
        total++; if (display_number !== 14'd9999) $display("FAIL range_9999_disp: got %0d expected 9999", display_number); else passed++;
        pulse_ent();
    endtask

    task automatic test_timeout();
        pulse_ent();
        pulse_ent();
        for (int i = 0; i < 63; i++) tick();
        total++; if (dbg_state !== COMPUTE) $display("FAIL timeout_early: got %0d expected %0d", dbg_state, COMPUTE); else passed++;
        tick();
        total++; if (dbg_state !== ERROR || error !== 1'b1) $display("FAIL timeout_err: got %0d/%0b expected %0d/1", dbg_state, error, ERROR); else passed++;
        pulse_done(14'd5, 1'b0);
        tick();
        total++; if (dbg_state !== ERROR || error !== 1'b1) $display("FAIL timeout_late_done: got %0d/%0b expected %0d/1", dbg_state, error, ERROR); else passed++;
        total++; if (display_number !== 14'd9999) $display("FAIL timeout_result_kept: got %0d expected 9999", display_number); else passed++;
        pulse_clr();
        total++; if (dbg_state !== ENTER_A || operand_clr !== 1'b1) $display("FAIL timeout_clr: got %0d/%0b expected %0d/1", dbg_state, operand_clr, ENTER_A); else passed++;
    endtask

    task automatic test_clr_ent();
        tick();
        pulse_ent();
        btn_clr = 1'b1;
        btn_ent = 1'b1;
        tick();
        btn_clr = 1'b0;
        btn_ent = 1'b0;
        total++; if (dbg_state !== ENTER_A || write_sel !== 1'b0) $display("FAIL clrent_state: got %0d/%0b expected %0d/0", dbg_state, write_sel, ENTER_A); else passed++;
        total++; if (operand_clr !== 1'b1 || alu_if.alu_start !== 1'b0) $display("FAIL clrent_pulses: got clr=%0b start=%0b expected clr=1 start=0", operand_clr, alu_if.alu_start); else passed++;
        pulse_done(14'd77, 1'b1);
        total++; if (dbg_state !== ENTER_A || error !== 1'b0) $display("FAIL stray_done: got %0d/%0b expected %0d/0", dbg_state, error, ENTER_A); else passed++;
    endtask

    task automatic test_clr_done();
        pulse_ent();
        pulse_ent();
        btn_clr = 1'b1;
        pulse_done(14'd77, 1'b0);
        btn_clr = 1'b0;
        total++; if (dbg_state !== ENTER_A || operand_clr !== 1'b1) $display("FAIL clrdone_state: got %0d/%0b expected %0d/1", dbg_state, operand_clr, ENTER_A); else passed++;
        total++; if (dut.r_result_q !== 14'd0) $display("FAIL clrdone_result: got %0d expected 0", dut.r_result_q); else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset = 1'b1;
        btn_ent = 1'b0;
        btn_clr = 1'b0;
        arith_sel = 1'b0;
        number_1 = 14'd12;
        number_2 = 14'd30;
        alu_if.alu_done = 1'b0;
        alu_if.alu_result = '0;
        alu_if.alu_overflow = 1'b0;
        #1;
        test_reset();
        test_add();
        test_overflow();
        test_range();
        test_timeout();
        test_clr_ent();
        test_clr_done();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
